slatch_arb: RTL and testbench
=============================

# slatch_arb

Round-robin arbitrated shared register for Blink-style status/control latches. Up to N requesters write one W-bit register through independent 4-phase req/ack handshakes. Each write is a load, set, clear or toggle operation. Fairness is rotating-priority, which replaces fixed-priority sharing where several engines (RTC, keyboard scan, CPU port writes, UART) update the same latch.

## Interface
- N, default 4: number of requesters (2..8).
- W, default 8: register width.
- INIT, default 0: value of q after reset.
- IW, default 2: width of grant index; must equal ceil(log2(N)), minimum 1.

- clk  input  1  single clock; all logic on rising edge.
- res  input  1  reset, synchronous, active-high.
- req  input  N  per-requester request, bit i = requester i.
- op  input  2*N  per-requester operation; bits [2i+1:2i] belong to requester i.
- d  input  W*N  per-requester operand; bits [W*i+W-1:W*i] belong to requester i.
- ack  output  N  per-requester acknowledge, registered.
- q  output  W  register value, registered.
- upd  output  1  one-cycle pulse: a grant was applied at the last edge.
- gnt_idx  output  IW  index of last granted requester, registered.

## Operation
- Reset (res=1 at an edge): q=INIT, ack=0, upd=0, gnt_idx=0, priority pointer ptr=0 (requester 0 highest). Reset overrides all other activity.
- Eligible(i) = req[i] & ~ack[i].
- Handshake, 4-phase per requester:
  - Requester raises req with op/d stable.
  - Arbiter applies the op and raises ack.
  - Requester drops req.
  - Arbiter drops ack.
  - op/d must stay stable while req=1 and ack=0.
- ack clear: at each edge, for every i with req[i]=0, ack[i]<=0. Independent of arbitration.
- Arbitration: at each edge, among eligible requesters, choose the first found scanning ptr, ptr+1, ..., wrapping modulo N. At most one grant per edge.
- Grant to requester g at an edge:
  - ack[g]<=1, gnt_idx<=g, upd<=1, ptr<=(g+1) mod N.
  - q updated per op[g]:
    - 00 load: q<=d[g].
    - 01 set: q<=q|d[g].
    - 10 clear: q<=q&~d[g].
    - 11 toggle: q<=q^d[g].
- No eligible requester: q, ptr and gnt_idx hold; upd<=0.
- A requester holding req=1 with ack=1 is never re-granted. A new write requires req to drop, ack to clear, then req to rise again.
- Request withdrawn before ack (protocol violation): the request is lost silently, with no effect on q or ptr.
- Reset mid-handshake: all ack cleared. Any requester still holding req=1 after reset is eligible again, so its op is re-applied on top of INIT. This is required behaviour and requesters must tolerate it.
- Arithmetic is bitwise only; no carries. Indices wrap modulo N, including non-power-of-two N.

## Timing
- Grant latency:
  - req[i] sampled high at edge k with i winning: q, ack[i], upd and gnt_idx valid after edge k.
  - Minimum 1 cycle from req rise to ack.
  - A requester losing arbitration waits ≤ N-1 additional edges, given all competitors complete handshakes normally.
- ack fall: 1 edge after req sampled low.
- Minimum full handshake for one requester: 4 edges (req↑ → ack↑ → req↓ → ack↓), requester-limited.
- Throughput: one write per clock across all requesters.
- Simultaneous ack clear of requester j and grant of requester i≠j in the same edge: both take effect.
- upd is high exactly one cycle per grant. Back-to-back grants keep upd high continuously.
- No combinational path from inputs to outputs.

## Test plan
- Reset:
  - Stimulus: res=1 for 2 cycles with req=4'b1111.
  - Required: q=8'h00, ack=0, upd=0, gnt_idx=0 throughout.
  - After release: first grant to requester 0 on the first edge.
- Single load:
  - Stimulus: requester 2 op=00, d=8'hA5.
  - Required: q=8'hA5, ack=4'b0100 and upd=1 one edge after req sampled.
  - Then drop req: ack=0 one edge later, and upd=0.
- Ops chain, requester 1 sequential handshakes from q=8'hA5:
  - set 8'h0F → q=8'hAF.
  - clear 8'hA0 → q=8'h0F.
  - toggle 8'hFF → q=8'hF0.
  - load 8'h3C → q=8'h3C.
- Simultaneous contention:
  - Stimulus: after reset, all four raise req in the same cycle with load d=8'h10, 8'h11, 8'h12, 8'h13.
  - Required: grants on 4 consecutive edges in order 0, 1, 2, 3.
  - gnt_idx sequence 0, 1, 2, 3; final q=8'h13; upd high for 4 cycles.
- Fairness:
  - Stimulus: requester 0 re-handshakes as fast as possible while requester 3 holds req.
  - Required: requester 3 is granted within 2 grant slots after its request is sampled.
  - Requester 0 is never granted twice consecutively while requester 3 is eligible.
- Reset mid-handshake:
  - Stimulus: requester 1 set d=8'h01 acked with q=8'h81, then res pulse while req[1]=1.
  - Required: q=8'h00 and ack=0 after reset.
  - First edge after release: q=8'h01, ack[1]=1.

Source files
------------

// File: rtl/slatch_arb.sv
// slatch_arb: shared W-bit status/control latch written by N requesters over
// independent 4-phase req/ack handshakes. Each write is load/set/clear/toggle.
// Rotating-priority arbitration grants at most one write per clock.
module slatch_arb #(
    parameter int             N    = 4,
    parameter int             W    = 8,
    parameter logic [W-1:0]   INIT = '0,
    parameter int             IW   = 2
) (
    input  logic              clk,
    input  logic              res,
    input  logic [N-1:0]      req,
    input  logic [2*N-1:0]    op,
    input  logic [W*N-1:0]    d,
    output logic [N-1:0]      ack,
    output logic [W-1:0]      q,
    output logic              upd,
    output logic [IW-1:0]     gnt_idx
);

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_SET    = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    logic [N-1:0]  r_ack;
    logic [W-1:0]  r_q;
    logic          r_upd;
    logic [IW-1:0] r_gnt_idx;
    logic [IW-1:0] r_ptr;

    logic [N-1:0]  w_elig;
    logic          w_found;
    logic [IW-1:0] w_gnt;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] w_ptr_nxt;
    logic [1:0]    w_op;
    logic [W-1:0]  w_d;
    logic [W-1:0]  w_q_nxt;
    logic [N-1:0]  w_gnt_oh;

    // A requester already acked while still holding req is not eligible, so a
    // held request never receives a second grant.
    assign w_elig = req & ~r_ack;

    // Scan from the priority pointer, wrapping at N (works for non-power-of-two N).
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = r_ptr;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
            w_idx = (w_idx == IW'(N - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    // Winner's operation, operand, next pointer and one-hot ack bit.
    always_comb begin
        w_op      = op[2*int'(w_gnt) +: 2];
        w_d       = d[W*int'(w_gnt) +: W];
        w_ptr_nxt = (w_gnt == IW'(N - 1)) ? '0 : w_gnt + 1'b1;
        w_gnt_oh  = '0;
        w_gnt_oh[w_gnt] = w_found;
        case (op_e'(w_op))
            OP_LOAD:   w_q_nxt = w_d;
            OP_SET:    w_q_nxt = r_q | w_d;
            OP_CLEAR:  w_q_nxt = r_q & ~w_d;
            OP_TOGGLE: w_q_nxt = r_q ^ w_d;
            default:   w_q_nxt = r_q;
        endcase
    end

    // Register update: ack clears follow req independently of the grant, so a
    // clear for one requester and a grant for another land on the same edge.
    always_ff @(posedge clk) begin
        if (res) begin
            r_ack     <= '0;
            r_q       <= INIT;
            r_upd     <= 1'b0;
            r_gnt_idx <= '0;
            r_ptr     <= '0;
        end else begin
            r_ack <= (r_ack & req) | w_gnt_oh;
            r_upd <= w_found;
            if (w_found) begin
                r_q       <= w_q_nxt;
                r_gnt_idx <= w_gnt;
                r_ptr     <= w_ptr_nxt;
            end
        end
    end

    assign ack     = r_ack;
    assign q       = r_q;
    assign upd     = r_upd;
    assign gnt_idx = r_gnt_idx;

endmodule

// File: tb/tb_slatch_arb.sv
// Self-checking bench for slatch_arb (N=4, W=8, INIT=0): directed scenarios
// plus randomized handshakes compared against a behavioural model.
module tb_slatch_arb;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           res;
    logic [N-1:0]   req;
    logic [2*N-1:0] op;
    logic [W*N-1:0] d;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic           upd;
    logic [1:0]     gnt_idx;

    int n_checks = 0;
    int n_fail   = 0;

    slatch_arb #(.N(N), .W(W), .INIT(8'h00), .IW(2)) dut (
        .clk(clk), .res(res), .req(req), .op(op), .d(d),
        .ack(ack), .q(q), .upd(upd), .gnt_idx(gnt_idx)
    );

    always #5 clk = ~clk;

    // Reference model: one write per edge, first eligible requester in
    // rotating order starting at the pointer.
    logic [W-1:0] m_q;
    logic [N-1:0] m_ack;
    logic         m_upd;
    int           m_gnt;
    int           m_ptr;
    initial begin
        m_q = '0; m_ack = '0; m_upd = 1'b0; m_gnt = 0; m_ptr = 0;
    end

    always @(posedge clk) begin : model
        int g;
        int j;
        logic [W-1:0] dv;
        logic [W-1:0] nq;
        if (res) begin
            m_q <= '0; m_ack <= '0; m_upd <= 1'b0; m_gnt <= 0; m_ptr <= 0;
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (g < 0 && req[j] && !m_ack[j]) g = j;
            end
            nq = m_q;
            if (g >= 0) begin
                dv = d[W*g +: W];
                case (op[2*g +: 2])
                    2'd0:    nq = dv;
                    2'd1:    nq = m_q | dv;
                    2'd2:    nq = m_q & ~dv;
                    default: nq = m_q ^ dv;
                endcase
                m_ack <= (m_ack & req) | (4'b0001 << g);
                m_gnt <= g;
                m_ptr <= (g + 1) % N;
            end else begin
                m_ack <= m_ack & req;
            end
            m_upd <= (g >= 0);
            m_q   <= nq;
        end
    end

    task automatic step;
        @(negedge clk);
    endtask

    task automatic test_reset;
        res = 1'b1; req = 4'b1111; op = '0; d = {8'h13, 8'h12, 8'h11, 8'h5A};
        for (int c = 0; c < 2; c++) begin
            step();
            n_checks++;
            if (q !== 8'h00 || ack !== 4'b0000 || upd !== 1'b0 || gnt_idx !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_hold c=%0d: q=%h ack=%b upd=%b gnt=%0d, want q=00 ack=0000 upd=0 gnt=0",
                         c, q, ack, upd, gnt_idx);
            end
        end
        res = 1'b0;
        step();
        n_checks++;
        if (ack !== 4'b0001 || gnt_idx !== 2'd0 || upd !== 1'b1 || q !== 8'h5A) begin
            n_fail++;
            $display("FAIL reset_first_grant: ack=%b gnt=%0d upd=%b q=%h, want ack=0001 gnt=0 upd=1 q=5a",
                     ack, gnt_idx, upd, q);
        end
        req = '0;
        step();
        step();
    endtask

    task automatic test_single_load;
        op[5:4] = 2'b00; d[23:16] = 8'hA5; req = 4'b0100;
        step();
        n_checks++;
        if (q !== 8'hA5 || ack !== 4'b0100 || upd !== 1'b1 || gnt_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL single_load: q=%h ack=%b upd=%b gnt=%0d, want q=a5 ack=0100 upd=1 gnt=2",
                     q, ack, upd, gnt_idx);
        end
        req = '0;
        step();
        n_checks++;
        if (ack !== 4'b0000 || upd !== 1'b0 || q !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_release: ack=%b upd=%b q=%h, want ack=0000 upd=0 q=a5", ack, upd, q);
        end
    endtask

    task automatic test_ops_chain;
        logic [1:0] ops [4];
        logic [7:0] dvs [4];
        logic [7:0] exp [4];
        ops = '{2'b01, 2'b10, 2'b11, 2'b00};
        dvs = '{8'h0F, 8'hA0, 8'hFF, 8'h3C};
        exp = '{8'hAF, 8'h0F, 8'hF0, 8'h3C};
        for (int i = 0; i < 4; i++) begin
            op[3:2] = ops[i]; d[15:8] = dvs[i]; req = 4'b0010;
            step();
            n_checks++;
            if (q !== exp[i] || ack !== 4'b0010 || gnt_idx !== 2'd1) begin
                n_fail++;
                $display("FAIL ops_chain[%0d]: q=%h ack=%b gnt=%0d, want q=%h ack=0010 gnt=1",
                         i, q, ack, gnt_idx, exp[i]);
            end
            req = '0;
            step();
            n_checks++;
            if (ack !== 4'b0000) begin
                n_fail++;
                $display("FAIL ops_chain_release[%0d]: ack=%b, want 0000", i, ack);
            end
        end
    endtask

    task automatic test_contention;
        res = 1'b1; req = '0;
        step();
        res = 1'b0; op = '0; d = {8'h13, 8'h12, 8'h11, 8'h10}; req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if (gnt_idx !== 2'(k) || upd !== 1'b1 || q !== 8'(8'h10 + k) || ack[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL contention[%0d]: gnt=%0d upd=%b q=%h ack=%b, want gnt=%0d upd=1 q=%h",
                         k, gnt_idx, upd, q, ack, k, 8'(8'h10 + k));
            end
        end
        step();
        n_checks++;
        if (upd !== 1'b0 || q !== 8'h13 || ack !== 4'b1111) begin
            n_fail++;
            $display("FAIL contention_hold: upd=%b q=%h ack=%b, want upd=0 q=13 ack=1111", upd, q, ack);
        end
        req = '0;
        step();
        n_checks++;
        if (ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL contention_release: ack=%b, want 0000", ack);
        end
    endtask

    task automatic test_fairness;
        int  slots = 0;
        int  last  = -1;
        bit  got3  = 1'b0;
        bit  e3;
        op[1:0] = 2'b11; d[7:0] = 8'h01;
        op[7:6] = 2'b00; d[31:24] = 8'h77;
        req = 4'b0001;
        for (int c = 0; c < 30; c++) begin
            if (c == 3 && !got3) req[3] = 1'b1;
            e3 = req[3] && !ack[3];
            step();
            n_checks++;
            if (q !== m_q || ack !== m_ack || upd !== m_upd || (m_upd && gnt_idx !== 2'(m_gnt))) begin
                n_fail++;
                $display("FAIL fairness_model c=%0d: q=%h ack=%b upd=%b gnt=%0d, want q=%h ack=%b upd=%b gnt=%0d",
                         c, q, ack, upd, gnt_idx, m_q, m_ack, m_upd, m_gnt);
            end
            if (upd === 1'b1) begin
                if (gnt_idx == 2'd3) got3 = 1'b1;
                else if (e3) slots++;
                if (gnt_idx == 2'd0 && last == 0 && e3) begin
                    n_fail++;
                    $display("FAIL fairness_repeat c=%0d: requester 0 granted twice while 3 eligible", c);
                end
                last = int'(gnt_idx);
            end
            if (req[0] && ack[0]) req[0] = 1'b0;
            else if (!req[0] && !ack[0]) req[0] = 1'b1;
            if (got3 && ack[3]) req[3] = 1'b0;
        end
        n_checks++;
        if (!got3 || slots > 1) begin
            n_fail++;
            $display("FAIL fairness_latency: got3=%0d other_grants_while_waiting=%0d, want got3=1 and <=1",
                     got3, slots);
        end
        req = '0;
        step();
        step();
    endtask

    task automatic test_reset_mid;
        op[1:0] = 2'b00; d[7:0] = 8'h80; req = 4'b0001;
        step();
        req = '0;
        step();
        op[3:2] = 2'b01; d[15:8] = 8'h01; req = 4'b0010;
        step();
        n_checks++;
        if (q !== 8'h81 || ack !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_mid_pre: q=%h ack=%b, want q=81 ack=0010", q, ack);
        end
        res = 1'b1;
        step();
        n_checks++;
        if (q !== 8'h00 || ack !== 4'b0000 || upd !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_in: q=%h ack=%b upd=%b, want q=00 ack=0000 upd=0", q, ack, upd);
        end
        res = 1'b0;
        step();
        n_checks++;
        if (q !== 8'h01 || ack !== 4'b0010 || gnt_idx !== 2'd1 || upd !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_reapply: q=%h ack=%b gnt=%0d upd=%b, want q=01 ack=0010 gnt=1 upd=1",
                     q, ack, gnt_idx, upd);
        end
        req = '0;
        step();
    endtask

    task automatic test_random;
        for (int c = 0; c < 500; c++) begin
            res = ($urandom_range(63) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req[i] && !ack[i]) begin
                    if ($urandom_range(2) == 0) begin
                        req[i] = 1'b1;
                        op[2*i +: 2] = 2'($urandom);
                        d[W*i +: W]  = 8'($urandom);
                    end
                end else if (req[i] && ack[i]) begin
                    if ($urandom_range(1) == 0) req[i] = 1'b0;
                end else if (req[i] && !ack[i]) begin
                    if ($urandom_range(31) == 0) req[i] = 1'b0;
                end
            end
            step();
            n_checks++;
            if (q !== m_q || ack !== m_ack || upd !== m_upd || gnt_idx !== 2'(m_gnt)) begin
                n_fail++;
                $display("FAIL random c=%0d: q=%h ack=%b upd=%b gnt=%0d, want q=%h ack=%b upd=%b gnt=%0d",
                         c, q, ack, upd, gnt_idx, m_q, m_ack, m_upd, m_gnt);
            end
        end
        res = 1'b0;
        req = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_ops_chain();
        test_contention();
        test_fairness();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
